// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables and NOP-injection controls,
// load-use / branch / memory-stall resolution, HLT drain, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 4,
    parameter int CNT_W   = 16,
    parameter int DRAIN_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_halt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int DCNT_W = $clog2(DRAIN_N + 1);

    state_t              state_r;
    logic [DCNT_W-1:0]   drain_cnt_r;
    logic                kill_pend_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [CNT_W-1:0]    flush_cnt_r;
    logic                load_use_s;
    logic                halt_go_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Load-use detection: R0 never carries a real dependency.
    always_comb begin
        load_use_s = ex_memread && (ex_rd != REG_W'(0)) &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    end

    // Stage enable / flush decode from state and current hazards.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        halted     = 1'b0;
        halt_go_s  = 1'b0;
        if (rst) begin
            halted = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (dmem_stall) begin
                        pc_en = 1'b0;
                    end else if (load_use_s) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (id_halt) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        halt_go_s  = 1'b1;
                    end else begin
                        // A taken branch redirects even while the fetch is pending.
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        pc_en      = br_taken | ~imem_stall;
                        ifid_flush = br_taken | imem_stall | kill_pend_r;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_stall) begin
                        pc_en = 1'b0;
                    end else begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    // FSM, stale-fetch tracking and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= DCNT_W'(0);
            kill_pend_r <= 1'b0;
            stall_cnt_r <= CNT_W'(0);
            flush_cnt_r <= CNT_W'(0);
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!pc_en) begin
                        stall_cnt_r <= sat_inc(stall_cnt_r);
                    end
                    if (ifid_flush || idex_flush) begin
                        flush_cnt_r <= sat_inc(flush_cnt_r);
                    end
                    if (halt_go_s) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= DCNT_W'(0);
                        kill_pend_r <= 1'b0;
                    end else if (!dmem_stall && !load_use_s) begin
                        // Pending kill survives only while the fetch is still outstanding.
                        if (br_taken) begin
                            kill_pend_r <= imem_stall;
                        end else if (!imem_stall) begin
                            kill_pend_r <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!dmem_stall) begin
                        if (drain_cnt_r == DCNT_W'(DRAIN_N - 1)) begin
                            state_r <= ST_HALT;
                        end else begin
                            drain_cnt_r <= drain_cnt_r + DCNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W   = 4;
    localparam int CNT_W   = 8;
    localparam int DRAIN_N = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_use_rs, id_use_rt, id_halt, ex_memread, br_taken, imem_stall, dmem_stall;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       dut_v;
    logic [7:0]       exp_v;

    int checks = 0;
    int errors = 0;

    // reference model state: mode 0=running 1=draining 2=halted
    int m_mode, m_adv, m_scnt, m_fcnt;
    bit m_kill;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .DRAIN_N(DRAIN_N)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_halt(id_halt), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign dut_v = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted};

    function automatic bit m_load_use();
        return ex_memread && (ex_rd != 0) &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    // expected {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb, halted}
    function automatic logic [7:0] model_outs();
        bit pc, ifd, ifdf, idx, idxf, exm, mwb;
        if (rst) return 8'h00;
        if (m_mode == 2) return 8'h01;
        if (dmem_stall) return 8'h00;
        pc = 1; ifd = 1; ifdf = 0; idx = 1; idxf = 0; exm = 1; mwb = 1;
        if (m_mode == 1) begin
            pc = 0; ifdf = 1;
        end else if (m_load_use()) begin
            pc = 0; ifd = 0; idxf = 1;
        end else if (id_halt) begin
            pc = 0; ifdf = 1;
        end else begin
            if (br_taken) ifdf = 1;
            else if (imem_stall) begin pc = 0; ifdf = 1; end
            if (m_kill) ifdf = 1;
        end
        return {pc, ifd, ifdf, idx, idxf, exm, mwb, 1'b0};
    endfunction

    task automatic model_step();
        logic [7:0] o;
        o = model_outs();
        if (rst) begin
            m_mode = 0; m_adv = 0; m_kill = 0; m_scnt = 0; m_fcnt = 0;
        end else if (m_mode == 0) begin
            if (!o[7] && m_scnt < CMAX) m_scnt++;
            if ((o[5] || o[3]) && m_fcnt < CMAX) m_fcnt++;
            if (!dmem_stall && !m_load_use()) begin
                if (id_halt) begin m_mode = 1; m_adv = 0; m_kill = 0; end
                else if (br_taken) m_kill = imem_stall;
                else if (!imem_stall) m_kill = 0;
            end
        end else if (m_mode == 1) begin
            if (!dmem_stall) m_adv++;
            if (m_adv == DRAIN_N) m_mode = 2;
        end
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0; id_halt = 0;
        ex_memread = 0; br_taken = 0; imem_stall = 0; dmem_stall = 0;
    endtask

    // model update, then clock edge; inputs change 1 ns after the edge
    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        adv();
        rst = 0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_rd = 4'd3; id_rs = 4'd3; id_use_rs = 1; id_rt = 4'd7; id_use_rt = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        id_halt = 1; br_taken = 1; imem_stall = 1;
        @(negedge clk);
        checks++;
        if (dut_v !== 8'h00) begin errors++; $display("FAIL reset_outs: got %b want %b", dut_v, 8'h00); end
        adv();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        checks++;
        if (dut_v !== 8'hD6) begin errors++; $display("FAIL reset_run: got %b want %b", dut_v, 8'hD6); end
        adv();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        br_taken = 1;
        @(negedge clk);
        checks++;
        if (dut_v !== 8'h1E) begin errors++; $display("FAIL load_use_bubble: got %b want %b", dut_v, 8'h1E); end
        adv();
        idle();
        @(negedge clk);
        checks++;
        if (dut_v !== 8'hD6) begin errors++; $display("FAIL load_use_after: got %b want %b", dut_v, 8'hD6); end
        checks++;
        if (stall_cnt !== 1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); end
        adv();
    endtask

    task automatic test_r0_no_stall();
        do_reset();
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        @(negedge clk);
        checks++;
        if (dut_v !== 8'hD6) begin errors++; $display("FAIL r0_no_stall: got %b want %b", dut_v, 8'hD6); end
        adv();
        idle();
    endtask

    task automatic test_branch_kill();
        do_reset();
        br_taken = 1; imem_stall = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) br_taken = 0;
            if (i == 4) imem_stall = 0;
            @(negedge clk);
            exp_v = model_outs();
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL branch_kill c%0d: got %b want %b", i, dut_v, exp_v); end
            checks++;
            if (ifid_flush !== 1'b1) begin errors++; $display("FAIL branch_kill_flush c%0d: got %b want 1", i, ifid_flush); end
            adv();
        end
        @(negedge clk);
        checks++;
        if (flush_cnt !== 5 || ifid_flush !== 1'b0) begin
            errors++; $display("FAIL branch_kill_cnt: got %0d/%b want 5/0", flush_cnt, ifid_flush);
        end
        adv();
    endtask

    task automatic test_dmem_load_use();
        do_reset();
        set_load_use();
        dmem_stall = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dmem_stall = 0;
            @(negedge clk);
            exp_v = (i < 4) ? 8'h00 : 8'h1E;
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL dmem_load_use c%0d: got %b want %b", i, dut_v, exp_v); end
            adv();
        end
        idle();
    endtask

    task automatic test_halt_drain();
        int seq [6] = '{0, 0, 1, 1, 0, 0};
        do_reset();
        id_halt = 1;
        @(negedge clk);
        checks++;
        if (dut_v !== 8'h76) begin errors++; $display("FAIL halt_enter: got %b want %b", dut_v, 8'h76); end
        adv();
        idle();
        for (int i = 1; i < 6; i++) begin
            dmem_stall = seq[i][0];
            @(negedge clk);
            exp_v = model_outs();
            checks++;
            if (dut_v !== exp_v || halted !== 1'b0) begin errors++; $display("FAIL drain c%0d: got %b want %b", i, dut_v, exp_v); end
            adv();
        end
        dmem_stall = 0; br_taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== 8'h01) begin errors++; $display("FAIL halted c%0d: got %b want %b", i, dut_v, 8'h01); end
            adv();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            imem_stall = 1; br_taken = 1;
            adv();
            idle();
            id_halt = 1;
            adv();
            idle();
            for (int j = 0; j < k * 4; j++) adv();
            rst = 1;
            adv();
            rst = 0;
            @(negedge clk);
            checks++;
            if (dut_v !== 8'hD6 || stall_cnt !== 0 || flush_cnt !== 0) begin
                errors++; $display("FAIL reset_mid k%0d: got %b %0d %0d want %b 0 0", k, dut_v, stall_cnt, flush_cnt, 8'hD6);
            end
            adv();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        imem_stall = 1;
        for (int i = 0; i < CMAX + 10; i++) adv();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== CNT_W'(CMAX) || flush_cnt !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL saturate: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, CMAX, CMAX);
        end
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(99) < 2);
            id_rs      = REG_W'($urandom_range(3));
            id_rt      = REG_W'($urandom_range(3));
            ex_rd      = REG_W'($urandom_range(3));
            id_use_rs  = $urandom_range(1);
            id_use_rt  = $urandom_range(1);
            ex_memread = ($urandom_range(99) < 30);
            id_halt    = ($urandom_range(99) < 3);
            br_taken   = ($urandom_range(99) < 20);
            imem_stall = ($urandom_range(99) < 30);
            dmem_stall = ($urandom_range(99) < 15);
            @(negedge clk);
            exp_v = model_outs();
            checks++;
            if (dut_v !== exp_v) begin errors++; $display("FAIL random_outs c%0d: got %b want %b", i, dut_v, exp_v); end
            checks++;
            if (stall_cnt !== CNT_W'(m_scnt) || flush_cnt !== CNT_W'(m_fcnt)) begin
                errors++; $display("FAIL random_cnts c%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_scnt, m_fcnt);
            end
            adv();
        end
        idle();
    endtask

    initial begin
        idle();
        m_mode = 0; m_adv = 0; m_kill = 0; m_scnt = 0; m_fcnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_r0_no_stall();
        test_branch_kill();
        test_dmem_load_use();
        test_halt_drain();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
